// File: rtl/fft_frame_seq_if.sv
// Streaming FFT core channels seen by the frame sequencer: config, sample input, output-frame status.
// The master modport is the sequencer side; the slave modport is the FFT core side.
interface fft_frame_seq_if;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tlast;

    modport master (
        output cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast,
        input  cfg_tready, s_tready, m_tvalid, m_tlast
    );

    modport slave (
        input  cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast,
        output cfg_tready, s_tready, m_tvalid, m_tlast
    );
endinterface

// File: rtl/fft_frame_seq.sv
// Frame sequencer for the streaming FFT core: one-time config, decimated sample feed with tlast, drain wait.
// Optional drain watchdog enabled by defining FRAME_TIMEOUT_EN.
module fft_frame_seq #(
    parameter int          FRAME_LEN   = 8192,
    parameter int          IDX_W       = 13,
    parameter int          DECIM       = 8,
    parameter logic [7:0]  CFG_WORD    = 8'h01,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic                  fft_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [9:0]            ad_data,
    fft_frame_seq_if.master       fft,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            frame_cnt,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam int                DW       = $clog2(DECIM);
    localparam logic [DW-1:0]     DEC_LAST = DW'(DECIM - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, CFG, FILL, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic             cfg_done_q, cfg_done_d;
    logic [DW-1:0]    dec_q, dec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [9:0]       sdata_q, sdata_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             hs;

`ifdef FRAME_TIMEOUT_EN
    localparam int    TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tout_q, tout_d;
`endif

    assign hs = vld_q & fft.s_tready;

    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        dec_d      = dec_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        sdata_d    = sdata_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
`ifdef FRAME_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        tout_d     = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = cfg_done_q ? FILL : CFG;
                    dec_d   = '0;
                    ovr_d   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
                    tout_d  = 1'b0;
`endif
                end
            end
            CFG: begin
                if (fft.cfg_tready) begin
                    cfg_done_d = 1'b1;
                    dec_d      = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
                // A tick while a sample is still offered keeps the old one and flags the loss.
                if (dec_q == DEC_LAST) begin
                    if (vld_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        vld_d   = 1'b1;
                        sdata_d = ad_data;
                    end
                end
                if (hs) begin
                    vld_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = DRAIN;
`ifdef FRAME_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fft.m_tvalid && fft.m_tlast) begin
                    state_d = DONE;
`ifdef FRAME_TIMEOUT_EN
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fft_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_done_q <= 1'b0;
            dec_q      <= '0;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            sdata_q    <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            tcnt_q     <= '0;
            tout_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            dec_q      <= dec_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            sdata_q    <= sdata_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
`ifdef FRAME_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
            tout_q     <= tout_d;
`endif
        end
    end

    assign fft.cfg_tvalid = (state_q == CFG);
    assign fft.cfg_tdata  = (state_q == CFG) ? CFG_WORD : 8'h00;
    assign fft.s_tvalid   = vld_q;
    assign fft.s_tdata    = {16'h0000, 6'b000000, sdata_q};
    assign fft.s_tlast    = vld_q && (idx_q == IDX_LAST);
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);
    assign frame_cnt      = cnt_q;
    assign overrun        = ovr_q;
`ifdef FRAME_TIMEOUT_EN
    assign timeout_err    = tout_q;
`else
    assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_fft_frame_seq.sv
// Randomized bench for fft_frame_seq: per-frame scoreboard derives handshake cycles and data from logged inputs.
module tb_fft_frame_seq;
    localparam int FRAME_LEN = 16;
    localparam int DECIM     = 2;
    localparam int LOGN      = 65536;

    logic       fft_clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] ad_data;
    logic       busy, frame_done, overrun, timeout_err;
    logic [7:0] frame_cnt;

    fft_frame_seq_if fif ();

    fft_frame_seq #(
        .FRAME_LEN(FRAME_LEN), .IDX_W(4), .DECIM(DECIM), .CFG_WORD(8'h01), .TIMEOUT_CYC(100)
    ) dut (
        .fft_clk(fft_clk), .rst(rst), .start(start), .ad_data(ad_data), .fft(fif),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 fft_clk = ~fft_clk;

    typedef struct { int c; logic [31:0] d; logic l; } hs_t;

    hs_t        hs_q[$];
    hs_t        exp_q[$];
    bit [9:0]   ad_log[LOGN];
    bit         rdy_log[LOGN];
    bit         cfgr_log[LOGN];
    int         cyc = 0;
    int         rdy_mode = 0;
    int         stall_left = 0;
    bit         cfg_rand = 0;
    int         cfg_hi = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         prev_vld = 0, prev_rdy = 0;
    logic [31:0] prev_data = '0;
    bit         cfg_done_m = 0;
    int         cnt_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge fft_clk);
        #1;
        cyc++;
        ad_data = 10'($urandom);
        fif.cfg_tready = cfg_rand ? 1'($urandom % 2) : 1'b1;
        case (rdy_mode)
            0: fif.s_tready = 1'b1;
            1: fif.s_tready = (($urandom % 4) != 0);
            default: begin
                fif.s_tready = 1'b1;
                if (fif.s_tvalid && hs_q.size() == 3 && stall_left > 0) begin
                    fif.s_tready = 1'b0;
                    stall_left--;
                end
            end
        endcase
        if (cyc < LOGN) begin
            ad_log[cyc]   = ad_data;
            rdy_log[cyc]  = fif.s_tready;
            cfgr_log[cyc] = fif.cfg_tready;
        end
        if (prev_vld && !prev_rdy && !rst) begin
            check("hold_vld", 32'(fif.s_tvalid), 32'd1);
            check("hold_data", fif.s_tdata, prev_data);
        end
        if (fif.cfg_tvalid) begin
            cfg_hi++;
            check("cfg_data", 32'(fif.cfg_tdata), 32'h01);
        end
        if (fif.s_tvalid && fif.s_tready)
            hs_q.push_back('{c: cyc, d: fif.s_tdata, l: fif.s_tlast});
        prev_vld  = fif.s_tvalid;
        prev_rdy  = fif.s_tready;
        prev_data = fif.s_tdata;
    endtask

    // Expected accepted samples: ticks every DECIM cycles from FILL entry, one sample in flight at most.
    task automatic build_exp(input int fill_c, output bit ovr);
        int acc, ph, t, h;
        bit pend;
        exp_q.delete();
        ovr = 0; acc = 0; ph = 0; pend = 0;
        for (int k = 0; k < 4000; k++) begin
            t = fill_c + DECIM - 1 + k * DECIM;
            if (acc == FRAME_LEN && t > ph) break;
            if (t > cyc) break;
            if (pend && ph >= t) begin
                ovr = 1;
            end else if (acc < FRAME_LEN) begin
                h = t + 1;
                while (h <= cyc && !rdy_log[h]) h++;
                if (h > cyc) break;
                exp_q.push_back('{c: h, d: {22'd0, ad_log[t]}, l: (acc == FRAME_LEN - 1)});
                ph = h; pend = 1; acc++;
            end
        end
    endtask

    task automatic run_fill(input int mode, input bit crand);
        int c, h, fill_c, exp_cfg, w;
        bit ovr;
        rdy_mode = mode; cfg_rand = crand; stall_left = 5;
        hs_q.delete(); cfg_hi = 0;
        c = cyc;
        start = 1'b1; step(); start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        w = 0;
        while (hs_q.size() < FRAME_LEN && w < 2000) begin step(); w++; end
        check("hs_count", hs_q.size(), FRAME_LEN);
        step();
        if (!cfg_done_m) begin
            h = c + 1;
            while (h <= cyc && !cfgr_log[h]) h++;
            exp_cfg = h - c; fill_c = h + 1; cfg_done_m = 1;
        end else begin
            exp_cfg = 0; fill_c = c + 1;
        end
        check("cfg_cycles", cfg_hi, exp_cfg);
        build_exp(fill_c, ovr);
        check("exp_count", exp_q.size(), hs_q.size());
        for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) begin
            check("hs_cycle", hs_q[i].c, exp_q[i].c);
            check("hs_data", hs_q[i].d, exp_q[i].d);
            check("hs_last", 32'(hs_q[i].l), 32'(exp_q[i].l));
        end
        check("overrun", 32'(overrun), 32'(ovr));
        check("drain_busy0", 32'(busy), 32'd1);
        check("drain_svld0", 32'(fif.s_tvalid), 32'd0);
    endtask

    task automatic run_drain(input int n, input bit start_drain, input bit start_done);
        for (int i = 0; i < n; i++) begin
            fif.m_tvalid = 1'($urandom % 2);
            fif.m_tlast  = fif.m_tvalid ? 1'b0 : 1'($urandom % 2);
            start = start_drain && (i == n / 2);
            step();
            start = 1'b0;
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_svld", 32'(fif.s_tvalid), 32'd0);
            check("drain_done", 32'(frame_done), 32'd0);
        end
        fif.m_tvalid = 1'b1; fif.m_tlast = 1'b1;
        step();
        fif.m_tvalid = 1'b0; fif.m_tlast = 1'b0;
        start = start_done;
        check("done_pulse", 32'(frame_done), 32'd1);
        step();
        start = 1'b0;
        cnt_m = (cnt_m + 1) % 256;
        check("done_width", 32'(frame_done), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
        check("idle_busy", 32'(busy), 32'd0);
        step();
        check("idle_stays", 32'(busy), 32'd0);
        check("tout_flag", 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; ad_data = '0;
        fif.cfg_tready = 1'b1; fif.s_tready = 1'b1; fif.m_tvalid = 1'b0; fif.m_tlast = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfgv", 32'(fif.cfg_tvalid), 32'd0);
        check("rst_cfgd", 32'(fif.cfg_tdata), 32'd0);
        check("rst_svld", 32'(fif.s_tvalid), 32'd0);
        check("rst_sdata", fif.s_tdata, 32'd0);
        check("rst_slast", 32'(fif.s_tlast), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_tout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step();

        run_fill(0, 0);
        check("first_cfg_once", cfg_hi, 1);
        run_drain(3, 0, 0);
        run_fill(0, 0);
        check("second_no_cfg", cfg_hi, 0);
        run_drain(2, 1, 1);
        run_fill(2, 0);
        check("stall_overrun", 32'(overrun), 32'd1);
        run_drain(1, 0, 0);

        rdy_mode = 0; cfg_rand = 0; hs_q.delete();
        start = 1'b1; step(); start = 1'b0;
        w = 0;
        while ((hs_q.size() < 7 || !fif.s_tvalid) && w < 200) begin step(); w++; end
        check("pre_rst_cnt", 32'(frame_cnt), 32'(cnt_m));
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_svld", 32'(fif.s_tvalid), 32'd0);
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_cfgv", 32'(fif.cfg_tvalid), 32'd0);
        cfg_done_m = 0; cnt_m = 0;
        step();

        run_fill(1, 1);
        check("reconfig", 32'(cfg_hi > 0), 32'd1);
        run_drain(2, 0, 0);
        while (cnt_m != 255) begin
            run_fill($urandom % 2, 0);
            run_drain($urandom_range(0, 4), $urandom % 2, $urandom % 2);
        end
        run_fill(1, 0);
        run_drain(4, 1, 1);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);

        run_fill(0, 0);
`ifdef FRAME_TIMEOUT_EN
        begin
            int e;
            bit seen;
            e = cyc; seen = 0; w = 0;
            while (!timeout_err && w < 300) begin
                step(); w++;
                if (frame_done) seen = 1;
            end
            check("tout_delay", cyc - e, 100);
            check("tout_set", 32'(timeout_err), 32'd1);
            check("tout_idle", 32'(busy), 32'd0);
            check("tout_nodone", 32'(seen), 32'd0);
            check("tout_cnt", 32'(frame_cnt), 32'(cnt_m));
            run_fill(0, 0);
            check("tout_clear", 32'(timeout_err), 32'd0);
            run_drain(1, 0, 0);
        end
`else
        repeat (150) step();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_tout", 32'(timeout_err), 32'd0);
        check("wait_nodone", 32'(frame_done), 32'd0);
        run_drain(2, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
